// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Data-memory size/sign codes: bit 2 requests sign extension on reads.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BS = 3'b100;
  localparam logic [2:0] SZ_HS = 3'b101;

  // RISC-V load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store funct3
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

endpackage

// File: rtl/lsu_decode.sv
// Decodes a memory request into DMEM size code, access width and error flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on the request inputs.
// Ports: we/funct3/addr in; size (DMEM code), nbytes (1/2/4), err out.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 128
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [2:0]  size,
  output logic [2:0]  nbytes,
  output logic        err
);

  logic        legal;
  logic [32:0] end_addr;

  always_comb begin
    size   = SZ_B;
    nbytes = 3'd1;
    legal  = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   begin size = SZ_B; nbytes = 3'd1; legal = 1'b1; end
        F3_SH:   begin size = SZ_H; nbytes = 3'd2; legal = 1'b1; end
        F3_SW:   begin size = SZ_W; nbytes = 3'd4; legal = 1'b1; end
        default: ;
      endcase
    end else begin
      case (funct3)
        F3_LB:   begin size = SZ_BS; nbytes = 3'd1; legal = 1'b1; end
        F3_LH:   begin size = SZ_HS; nbytes = 3'd2; legal = 1'b1; end
        F3_LW:   begin size = SZ_W;  nbytes = 3'd4; legal = 1'b1; end
        F3_LBU:  begin size = SZ_B;  nbytes = 3'd1; legal = 1'b1; end
        F3_LHU:  begin size = SZ_H;  nbytes = 3'd2; legal = 1'b1; end
        default: ;
      endcase
    end
  end

  // One bit wider than the address so addresses near 2^32 cannot wrap into range.
  assign end_addr = {1'b0, addr} + {30'd0, nbytes};

  assign err = !legal
             || (nbytes == 3'd2 && addr[0])
             || (nbytes == 3'd4 && addr[1:0] != 2'b00)
             || (end_addr > 33'(ADDR_LIMIT));

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute stage and a combinational-read DMEM.
// Latency: response valid 2 cycles after accept (1 cycle for erroneous requests).
// Backpressure: response held in RESP until resp_ready; no new accept until back in IDLE.
// Ports: req_* request handshake in, resp_* result handshake out, mem_* DMEM port.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  mem_size,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic [2:0]  dec_size;
  logic [2:0]  dec_nbytes;
  logic        dec_err;
  logic        accept;
  logic        we_q;
  logic        err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  lsu_decode #(.ADDR_LIMIT(ADDR_LIMIT)) u_decode (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .size   (dec_size),
    .nbytes (dec_nbytes),
    .err    (dec_err)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    // rst gates the write so a store caught in ACCESS by reset never reaches DMEM.
    mem_rw     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = dec_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_rw    = we_q && !rst;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= dec_err;
      size_q  <= dec_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      // Cleared here so an erroneous request, which skips ACCESS, reports zero.
      rdata_q <= '0;
    end else if (state == ST_ACCESS) begin
      rdata_q <= we_q ? 32'd0 : mem_rdata;
    end
  end

  // A request that decodes as legal is always a 1, 2 or 4 byte access.
  assert property (@(posedge clk) disable iff (rst)
    (accept && !dec_err) |-> (dec_nbytes inside {3'd1, 3'd2, 3'd4}));

  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 128, giving the data-memory size in bytes; valid byte addresses are 0..ADDR_LIMIT-1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the execute stage presents a memory request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: the RISC-V funct3 of the load or store.
REQ-008 The block SHALL have port req_addr, input, 32 bits: the effective byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: the store data.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a result is available.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: writeback accepts the result.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: the load result, extended as the access type requires.
REQ-013 The block SHALL have port resp_err, output, 1 bit: the request is misaligned, out of range, or has an illegal funct3.
REQ-014 The block SHALL have port mem_size, output, 3 bits: the data-memory size/sign code.
REQ-015 The block SHALL have port mem_rw, output, 1 bit: the data-memory write enable.
REQ-016 The block SHALL have port mem_addr, output, 32 bits: the data-memory byte address.
REQ-017 The block SHALL have port mem_wdata, output, 32 bits: the data-memory write data.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: the data-memory combinational read data.

Function
REQ-019 The block SHALL implement a three-state FSM: IDLE, ACCESS and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-021 On accept, req_we, the mapped mem_size, req_addr, req_wdata and the error flag SHALL be latched into registers that drive mem_size, mem_addr and mem_wdata.
REQ-022 Load funct3 SHALL map to mem_size as follows: LB 000 to 100, LH 001 to 101, LW 010 to 010, LBU 100 to 000, LHU 101 to 001; load funct3 values 011, 110 and 111 SHALL be illegal.
REQ-023 Store funct3 SHALL map to mem_size as follows: SB 000 to 000, SH 001 to 001, SW 010 to 010; any other store funct3 SHALL be illegal.
REQ-024 The error flag SHALL be set for an illegal funct3, for a halfword access with addr[0]=1, for a word access with addr[1:0]!=0, or when addr plus access bytes exceeds ADDR_LIMIT; this addition SHALL be computed 33 bits wide so it cannot wrap.
REQ-025 Transitions: IDLE goes to ACCESS on accept when the error flag is 0; IDLE goes directly to RESP on accept when the error flag is 1.
REQ-026 ACCESS SHALL always last exactly one cycle and then go to RESP.
REQ-027 mem_rw SHALL equal (state==ACCESS) AND store AND NOT rst; it SHALL be 0 in all other states.
REQ-028 At the end of ACCESS, a load SHALL register mem_rdata into resp_rdata; a store SHALL register 0.
REQ-029 In RESP, resp_valid SHALL be 1 and resp_rdata and resp_err SHALL be held stable until resp_ready=1, then the FSM SHALL return to IDLE.
REQ-030 A new request SHALL NOT be accepted in the cycle in which the response is consumed (no bypass).
REQ-031 Latency SHALL be as follows: for a request accepted at edge N, resp_valid is 1 from cycle N+2 (N+1 if erroneous).
REQ-032 An erroneous request SHALL never assert mem_rw, and SHALL report resp_rdata=0 with resp_err=1.

Reset
REQ-033 While rst=1 at a rising edge, the state SHALL become IDLE and all latched registers, resp_rdata and resp_err SHALL become 0.
REQ-034 While rst=1, mem_rw SHALL be 0 combinationally, so that a store in ACCESS is suppressed; resp_valid SHALL be 0 after the reset edge.
REQ-035 rst asserted in RESP SHALL discard the pending response.

Structure
REQ-036 A shared package lsu_pkg SHALL hold the FSM state type, the DMEM size codes (SZ_B, SZ_H, SZ_W, SZ_BS, SZ_HS) and the load/store funct3 constants.
REQ-037 One combinational sub-module, lsu_decode, SHALL map (req_we, req_funct3, req_addr) to (mem_size, access bytes, error flag).

Verification
REQ-038 Scenario SW then LW: SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> mem_rw high for exactly one cycle; the load returns 0xDEADBEEF with resp_err=0 at cycle N+2.
REQ-039 Scenario sign extension: after SB addr=0x20 data=0x80, LB returns 0xFFFFFF80 and LBU returns 0x00000080; after SH 0x8001 at 0x22, LH returns 0xFFFF8001 and LHU returns 0x00008001.
REQ-040 Scenario misaligned and illegal: LW addr=0x13, SH addr=0x21, and load funct3=011 -> each gives resp_err=1 and resp_rdata=0 at N+1; mem_rw is never asserted and memory is unchanged.
REQ-041 Scenario range: SW addr=124 is accepted with err=0; SW addr=126 and LB addr=128 give err=1.
REQ-042 Scenario backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0; a request presented meanwhile is accepted only after the handshake.
REQ-043 Scenario reset mid-store: assert rst during the ACCESS cycle of SW addr=0x30 data=0x12345678 -> mem_rw stays 0, a later LW at 0x30 returns the prior value, and resp_valid is 0 after reset.
